flag_condition_unit: RTL and testbench
======================================

Name: flag_condition_unit

Overview:
- Consumer side of the flags register: reads the stored O/S/C/Z flags and evaluates a 4-bit branch/conditional-execution code against them.
- Sits between decode/control and the PC-select logic.
- Forwards flag values being written in the same cycle, using the W_RF encoding, so there is no read-after-write bubble.
- Returns a registered taken/not-taken result through a one-entry valid/ready output stage.

Parameters:
- TAG_W, 4, width of the opaque request tag carried with each request to its result.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_cond  input  4  condition code (encoding below).
- req_tag  input  TAG_W  tag returned with the result.
- flag_O, flag_S, flag_C, flag_Z  input  1 each  current flags-register outputs.
- wr_O, wr_S, wr_C, wr_Z  input  1 each  flag values being written this cycle.
- W_RF  input  3  flag write-enable code, same encoding as the flags register.
- res_valid  output  1  result held.
- res_ready  input  1  consumer accepts the result.
- res_taken  output  1  condition evaluated true.
- res_tag  output  TAG_W  tag of the request that produced the result.
- res_flags  output  4  {O,S,C,Z} used for the evaluation.

Behaviour:
- Effective flags, combinational, per flag:
  - If W_RF updates that flag, use wr_x; otherwise use flag_x.
  - 001 → Z. 010 → S,Z. 011 → S,C,Z. 100 → O,S,C,Z.
  - 000, 101, 110, 111 → no flag updated.
- Condition encoding (E = effective flags):
  - 0: true.
  - 1: Z. 2: !Z.
  - 3: C. 4: !C.
  - 5: S. 6: !S.
  - 7: O. 8: !O.
  - 9: S^O (signed lt). 10: !(S^O) (signed ge).
  - 11: (S^O)|Z (signed le). 12: !((S^O)|Z) (signed gt).
  - 13: C|Z. 14: !C&!Z.
  - 15: false.
- req_ready = !res_valid || res_ready. This is combinational and must not depend on req_valid.
- Accept: req_valid && req_ready at a posedge.
  - res_valid <= 1.
  - res_taken <= eval(req_cond, E).
  - res_tag <= req_tag.
  - res_flags <= E.
  - Latency is exactly 1 cycle, request to res_valid.
- Drain: res_valid && res_ready with no accept in the same cycle → res_valid <= 0. res_taken, res_tag and res_flags keep their last values.
- Simultaneous drain and accept: res_valid stays 1, payload is replaced. This sustains one result per cycle.
- Stall: res_valid && !res_ready → req_ready = 0. The result payload is held stable, bit-for-bit, until accepted.
- Flags are sampled only in the accept cycle. Later flag or W_RF activity never alters a held result.
- Reset (RST=1 at posedge) overrides everything, including a simultaneous accept:
  - res_valid = 0, res_taken = 0, res_tag = 0, res_flags = 0.
  - A pending result is discarded.
  - req_ready = 1 in the cycle after reset.
- Outputs must never be X after the first reset edge, whatever the flag input values.
- No internal knowledge of the flags register timing. Forwarding is purely from W_RF/wr_x in the same cycle.

Test Plan:
- Reset then idle:
  - Drive RST=1 for 2 cycles with req_valid=1.
  - Required: res_valid=0, res_taken=0, res_tag=0, res_flags=0, req_ready=1.
- Full decode sweep:
  - Stimulus: flags O,S,C,Z = 0,1,0,0; W_RF=000; res_ready=1; issue cond 0..15 back-to-back with tag=cond.
  - Required: one result per cycle, each one cycle after its request.
  - Required taken pattern, cond 0..15: 1,0,1,0,1,1,0,0,1,1,0,1,0,0,1,0.
- Forwarding:
  - Stimulus: flags Z=0; W_RF=001, wr_Z=1; cond=1.
  - Required: res_taken=1, res_flags[0]=1.
  - Stimulus: W_RF=101, wr_Z=1.
  - Required: res_taken=0, since the unused code forwards nothing.
- Backpressure:
  - Stimulus: accept tag 3 (taken=1); hold res_ready=0 for 4 cycles while flags toggle and req_valid=1.
  - Required: req_ready=0 throughout; tag 3 and taken=1 stable.
  - Stimulus: release res_ready with a new request tag 4 pending.
  - Required: tag 4 appears the next cycle, with no gap.
- Reset mid-operation:
  - Stimulus: result tag 7 held with res_ready=0; assert RST together with req_valid=1.
  - Required: result dropped, res_valid=0, no tag 7 or new result emitted.
- Signed compare:
  - Stimulus: O=1,S=0,Z=0 with cond 9,10,11,12.
  - Required taken: 1,0,1,0.
  - Stimulus: repeat with Z=1.
  - Required taken: 1,0,1,0.

Source files
------------

// File: rtl/flag_condition_unit_if.sv
// flag_condition_unit_if
//   Request/result handshake bundle for the flag condition unit.
//   req_*  : condition evaluation request (valid/ready), opaque tag.
//   res_*  : registered result (valid/ready): taken bit, tag, flags used.
//   master : drives requests, consumes results (decode/control side).
//   slave  : the condition unit itself.
interface flag_condition_unit_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cond;
    logic [TAG_W-1:0] req_tag;
    logic             res_valid;
    logic             res_ready;
    logic             res_taken;
    logic [TAG_W-1:0] res_tag;
    logic [3:0]       res_flags;

    modport master (
        output req_valid, req_cond, req_tag, res_ready,
        input  req_ready, res_valid, res_taken, res_tag, res_flags
    );

    modport slave (
        input  req_valid, req_cond, req_tag, res_ready,
        output req_ready, res_valid, res_taken, res_tag, res_flags
    );
endinterface

// File: rtl/flag_condition_unit.sv
// flag_condition_unit
//   Evaluates a 4-bit condition code against the O/S/C/Z flags and returns a
//   registered taken/not-taken result through a one-entry output stage.
//   Flag values written in the same cycle (W_RF + wr_x) are forwarded so a
//   branch right after a flag-setting op sees the new flags.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   bus (slave)       req_valid/req_ready/req_cond/req_tag,
//                     res_valid/res_ready/res_taken/res_tag/res_flags
//   flag_O..flag_Z    current flags-register outputs
//   wr_O..wr_Z        flag values being written this cycle
//   W_RF              flag write-enable code (flags-register encoding)
module flag_condition_unit #(
    parameter int TAG_W = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    flag_condition_unit_if.slave  bus,
    input  logic                  flag_O,
    input  logic                  flag_S,
    input  logic                  flag_C,
    input  logic                  flag_Z,
    input  logic                  wr_O,
    input  logic                  wr_S,
    input  logic                  wr_C,
    input  logic                  wr_Z,
    input  logic [2:0]            W_RF
);
    logic [3:0] eff;   // {O,S,C,Z} after forwarding
    logic       taken;
    logic       accept;
    logic       sign_lt;

    logic             res_valid_q;
    logic             res_taken_q;
    logic [TAG_W-1:0] res_tag_q;
    logic [3:0]       res_flags_q;

    // Forwarding: each W_RF code updates a nested subset of the flags;
    // unused codes update nothing.
    always_comb begin
        eff = {flag_O, flag_S, flag_C, flag_Z};
        case (W_RF)
            3'b001: eff = {flag_O, flag_S, flag_C, wr_Z};
            3'b010: eff = {flag_O, wr_S,   flag_C, wr_Z};
            3'b011: eff = {flag_O, wr_S,   wr_C,   wr_Z};
            3'b100: eff = {wr_O,   wr_S,   wr_C,   wr_Z};
            default: ;
        endcase
    end

    assign sign_lt = eff[2] ^ eff[3];

    always_comb begin
        taken = 1'b0;
        case (bus.req_cond)
            4'd0:  taken = 1'b1;
            4'd1:  taken = eff[0];
            4'd2:  taken = ~eff[0];
            4'd3:  taken = eff[1];
            4'd4:  taken = ~eff[1];
            4'd5:  taken = eff[2];
            4'd6:  taken = ~eff[2];
            4'd7:  taken = eff[3];
            4'd8:  taken = ~eff[3];
            4'd9:  taken = sign_lt;
            4'd10: taken = ~sign_lt;
            4'd11: taken = sign_lt | eff[0];
            4'd12: taken = ~(sign_lt | eff[0]);
            4'd13: taken = eff[1] | eff[0];
            4'd14: taken = ~eff[1] & ~eff[0];
            default: taken = 1'b0;
        endcase
    end

    // Ready depends only on the output stage so the producer never sees a
    // combinational loop through req_valid.
    assign bus.req_ready = ~res_valid_q | bus.res_ready;
    assign accept        = bus.req_valid & bus.req_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            res_tag_q   <= '0;
            res_flags_q <= '0;
        end else if (accept) begin
            res_valid_q <= 1'b1;
            res_taken_q <= taken;
            res_tag_q   <= bus.req_tag;
            res_flags_q <= eff;
        end else if (bus.res_ready) begin
            // payload kept; only the valid bit drops on drain
            res_valid_q <= 1'b0;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_taken = res_taken_q;
    assign bus.res_tag   = res_tag_q;
    assign bus.res_flags = res_flags_q;
endmodule

// File: tb/tb_flag_condition_unit.sv
module tb_flag_condition_unit;
    localparam int TAG_W = 4;

    logic CLK = 1'b0;
    logic RST;
    logic flag_O, flag_S, flag_C, flag_Z;
    logic wr_O, wr_S, wr_C, wr_Z;
    logic [2:0] W_RF;

    always #5 CLK = ~CLK;

    flag_condition_unit_if #(.TAG_W(TAG_W)) bus ();

    flag_condition_unit #(.TAG_W(TAG_W)) dut (
        .CLK(CLK), .RST(RST), .bus(bus),
        .flag_O(flag_O), .flag_S(flag_S), .flag_C(flag_C), .flag_Z(flag_Z),
        .wr_O(wr_O), .wr_S(wr_S), .wr_C(wr_C), .wr_Z(wr_Z),
        .W_RF(W_RF)
    );

    typedef struct {
        logic       taken;
        logic [3:0] tag;
        logic [3:0] flags;
        bit         lat;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per transferred result.
    always @(negedge CLK) begin
        if (RST === 1'b0 && bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual_tag=%0h required=none", bus.res_tag);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("res_taken", {31'd0, bus.res_taken}, {31'd0, e.taken});
                check("res_tag",   {28'd0, bus.res_tag},   {28'd0, e.tag});
                check("res_flags", {28'd0, bus.res_flags}, {28'd0, e.flags});
                if (e.lat) check("latency", cyc, e.cyc + 1);
            end
        end
    end

    // Present a request; push the expectation in the cycle it is accepted.
    task automatic issue(input logic [3:0] cond, input logic [3:0] tag,
                         input logic exp_taken, input logic [3:0] exp_flags, input bit lat);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_cond  = cond;
        bus.req_tag   = tag;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (bus.req_ready === 1'b1) begin
                e.taken = exp_taken; e.tag = tag; e.flags = exp_flags;
                e.lat = lat; e.cyc = cyc;
                sbq.push_back(e);
                @(posedge CLK); #1;
                return;
            end
            @(posedge CLK); #1;
        end
        total++;
        bad++;
        $display("FAIL accept_timeout actual=not_accepted required=accepted tag=%0h", tag);
    endtask

    task automatic set_flags(input logic [3:0] f, input logic [2:0] w, input logic [3:0] wr);
        {flag_O, flag_S, flag_C, flag_Z} = f;
        W_RF = w;
        {wr_O, wr_S, wr_C, wr_Z} = wr;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    bit sweep_exp [16] = '{1,0,1,0,1,1,0,0,1,1,0,1,0,0,1,0};
    bit signed_exp [4] = '{1,0,1,0};

    initial begin
        RST = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_cond  = 4'd0;
        bus.req_tag   = 4'd5;
        bus.res_ready = 1'b0;
        set_flags(4'b1111, 3'b000, 4'b0000);

        // reset with a request pending
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_taken", {31'd0, bus.res_taken}, 32'd0);
        check("rst_res_tag",   {28'd0, bus.res_tag},   32'd0);
        check("rst_res_flags", {28'd0, bus.res_flags}, 32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge CLK); #1;
        RST = 1'b0;
        bus.req_valid = 1'b0;
        idle(1);

        // full decode sweep, back-to-back
        bus.res_ready = 1'b1;
        set_flags(4'b0100, 3'b000, 4'b0000);
        for (int c = 0; c < 16; c++)
            issue(c[3:0], c[3:0], sweep_exp[c], 4'b0100, 1'b1);
        idle(2);

        // forwarding
        set_flags(4'b0000, 3'b001, 4'b0001);
        issue(4'd1, 4'd1, 1'b1, 4'b0001, 1'b1);
        set_flags(4'b0000, 3'b101, 4'b0001);
        issue(4'd1, 4'd2, 1'b0, 4'b0000, 1'b1);
        set_flags(4'b0000, 3'b010, 4'b0111);      // S,Z forwarded; C stays 0
        issue(4'd3, 4'd3, 1'b0, 4'b0101, 1'b1);
        set_flags(4'b0000, 3'b100, 4'b1010);
        issue(4'd13, 4'd4, 1'b1, 4'b1010, 1'b1);
        set_flags(4'b1111, 3'b011, 4'b1000);      // O kept, S,C,Z cleared
        issue(4'd7, 4'd5, 1'b1, 4'b1000, 1'b1);
        idle(2);

        // backpressure
        bus.res_ready = 1'b0;
        set_flags(4'b0010, 3'b000, 4'b0000);
        issue(4'd3, 4'd3, 1'b1, 4'b0010, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_cond  = 4'd0;
        bus.req_tag   = 4'd4;
        for (int i = 0; i < 4; i++) begin
            set_flags(i[0] ? 4'b1111 : 4'b0000, i[1] ? 3'b100 : 3'b001, 4'b0101);
            @(negedge CLK);
            check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("stall_res_valid", {31'd0, bus.res_valid}, 32'd1);
            check("stall_res_tag",   {28'd0, bus.res_tag},   32'd3);
            check("stall_res_taken", {31'd0, bus.res_taken}, 32'd1);
            check("stall_res_flags", {28'd0, bus.res_flags}, 32'h2);
            @(posedge CLK); #1;
        end
        set_flags(4'b0000, 3'b000, 4'b0000);
        bus.res_ready = 1'b1;
        issue(4'd0, 4'd4, 1'b1, 4'b0000, 1'b1);
        idle(2);

        // reset while a result is held
        bus.res_ready = 1'b0;
        issue(4'd0, 4'd7, 1'b1, 4'b0000, 1'b0);
        bus.req_valid = 1'b1;
        bus.req_tag   = 4'd8;
        @(negedge CLK);
        check("held_tag7", {28'd0, bus.res_tag}, 32'd7);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        bus.req_valid = 1'b0;
        sbq.delete();
        @(negedge CLK);
        check("midrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("midrst_res_tag",   {28'd0, bus.res_tag},   32'd0);
        check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.res_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("midrst_no_result", {31'd0, bus.res_valid}, 32'd0);
        @(posedge CLK); #1;

        // signed compares
        set_flags(4'b1000, 3'b000, 4'b0000);
        for (int c = 0; c < 4; c++)
            issue(4'd9 + c[3:0], 4'd9 + c[3:0], signed_exp[c], 4'b1000, 1'b1);
        set_flags(4'b1001, 3'b000, 4'b0000);
        for (int c = 0; c < 4; c++)
            issue(4'd9 + c[3:0], 4'd9 + c[3:0], signed_exp[c], 4'b1001, 1'b1);
        idle(1);

        // wait for the scoreboard to drain
        for (int n = 0; n < 10 && sbq.size() != 0; n++) @(posedge CLK);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d_pending required=0", sbq.size());
        end
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
